stopwatch_ctrl: RTL and testbench

- Control FSM for the stopwatch datapath: centisecond/second/minute counters, the lap-result memory and the 7-segment display.
- Synchronises and debounces the start/stop button, the save button and the result-mode switch.
- Decodes them into one-cycle command pulses (run level, clear, lap write, lap read) and a lap-memory address scheduler.
- Drives the RGB status light; the counter/decoder datapath only obeys these commands.

---
 rtl/stopwatch_lap_if.sv | 39 +++
 rtl/stopwatch_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_lap_if.sv
// ---------------------------------------------------------------------------
// stopwatch_lap_if
// Command bundle from the stopwatch control FSM to the lap-result memory and
// the display mux.
//
// Semantics: lap_we and lap_re are single-cycle command pulses with no ready
// or back-pressure. The datapath must act on every cycle in which a pulse is
// high. The matching address (lap_waddr or lap_raddr) is valid in that same
// cycle. lap_count, lap_full and show_lap are levels.
//
// Signals:
//   lap_we     store the current display into slot lap_waddr
//   lap_waddr  write slot
//   lap_re     read slot lap_raddr onto the display
//   lap_raddr  read slot
//   lap_count  number of valid laps stored
//   lap_full   lap_count has reached the memory depth
//   show_lap   display shows lap memory instead of live counters
// Modports: master (controller drives), slave (datapath observes).
// ---------------------------------------------------------------------------
interface stopwatch_lap_if #(
  parameter int LAP_AW = 4
) ();
  logic              lap_we;
  logic [LAP_AW-1:0] lap_waddr;
  logic              lap_re;
  logic [LAP_AW-1:0] lap_raddr;
  logic [LAP_AW-1:0] lap_count;
  logic              lap_full;
  logic              show_lap;

  modport master (
    output lap_we, lap_waddr, lap_re, lap_raddr, lap_count, lap_full, show_lap
  );

  modport slave (
    input lap_we, lap_waddr, lap_re, lap_raddr, lap_count, lap_full, show_lap
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM for the stopwatch datapath. It synchronises and debounces the
// start/stop button, the save button and the result-mode switch. It turns
// them into run/clear levels and pulses, lap write and read pulses with slot
// addresses, and an RGB status light.
//
// Optional build macro STOPWATCH_LAP_RING_EN: when it is defined, saving
// while the memory is full overwrites the oldest slot, and recall starts at
// the oldest slot. When it is not defined, writes are dropped when the
// memory is full.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   btn, save      active-low buttons, asynchronous to clk
//   outres         result-mode switch (1 = recall mode), asynchronous
//   run            counters advance while high
//   clear          one-cycle pulse that zeroes the counters and the display
//   lap            lap-memory command bundle (master side)
//   ledr/ledg/ledb status light; exactly one colour is on
//   dbg_state      current FSM state, for observation
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LAP_DEPTH       = 10,
  parameter int LAP_AW          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn,
  input  logic                   save,
  input  logic                   outres,
  output logic                   run,
  output logic                   clear,
  stopwatch_lap_if.master        lap,
  output logic                   ledr,
  output logic                   ledg,
  output logic                   ledb,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_RECALL = 2'd3
  } state_t;

  localparam int                CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LAP_AW-1:0] DEPTH_V  = LAP_AW'(LAP_DEPTH);
`ifdef STOPWATCH_LAP_RING_EN
  localparam logic [LAP_AW-1:0] LAST_V   = LAP_AW'(LAP_DEPTH - 1);
`endif
  // Bit order {outres, save, btn}: the buttons rest high, the switch rests low.
  localparam logic [2:0]        DEB_RST  = 3'b011;

  // Input synchronisers and debouncers.
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic          btn_ev_q, btn_ev_d, save_ev_q, save_ev_d;

  assign raw = {outres, save, btn};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      // The counter only runs while the synchronised input disagrees with
      // the accepted level, so any bounce back sends it to zero.
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // A press is the accepted level going 1 -> 0. Releases make no event.
    btn_ev_d  = deb_q[0] & ~deb_d[0];
    save_ev_d = deb_q[1] & ~deb_d[1];
  end

  // Control FSM and command outputs.
  state_t            state_q, state_d;
  logic              run_q, run_d, clear_q, clear_d;
  logic              we_q, we_d, re_q, re_d;
  logic [LAP_AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d, count_q, count_d;
  logic [LAP_AW-1:0] raddr_inc;
  logic              full_q, full_d, show_q, show_d;
  logic              ledr_q, ledr_d, ledg_q, ledg_d, ledb_q, ledb_d;
  logic              save_cmd;

  always_comb begin
    state_d   = state_q;
    clear_d   = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    count_d   = count_q;
    raddr_inc = raddr_q + LAP_AW'(1);
    // When btn and save are pressed in the same cycle, btn wins.
    save_cmd  = save_ev_q & ~btn_ev_q;

    // The slot pointer and the count advance in the cycle after a write pulse,
    // so the datapath sees the old address together with lap_we.
    if (we_q) begin
`ifdef STOPWATCH_LAP_RING_EN
      waddr_d = (waddr_q == LAST_V) ? '0 : waddr_q + LAP_AW'(1);
      count_d = (count_q == DEPTH_V) ? count_q : count_q + LAP_AW'(1);
`else
      waddr_d = waddr_q + LAP_AW'(1);
      count_d = count_q + LAP_AW'(1);
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (btn_ev_q)                  state_d = S_RUN;
        else if (save_cmd && !deb_q[2]) clear_d = 1'b1;
      end
      S_RUN: begin
        if (btn_ev_q) state_d = S_PAUSED;
        else if (save_cmd) begin
`ifdef STOPWATCH_LAP_RING_EN
          we_d = 1'b1;
`else
          we_d = !full_q;
`endif
        end
      end
      S_PAUSED: begin
        if (btn_ev_q) state_d = S_RUN;
        else if (save_cmd) begin
          if (!deb_q[2]) begin
            clear_d = 1'b1;
            count_d = '0;
            waddr_d = '0;
            raddr_d = '0;
            state_d = S_IDLE;
          end else if (count_q != '0) begin
            state_d = S_RECALL;
            re_d    = 1'b1;
`ifdef STOPWATCH_LAP_RING_EN
            // Once the ring has wrapped, the oldest lap sits at the write pointer.
            raddr_d = full_q ? waddr_q : '0;
`else
            raddr_d = '0;
`endif
          end
        end
      end
      S_RECALL: begin
        if (btn_ev_q)      state_d = S_RUN;
        else if (!deb_q[2]) state_d = S_PAUSED;
        else if (save_cmd) begin
          // When the ring is full, count equals depth, so this also wraps
          // modulo the depth.
          raddr_d = (raddr_inc == count_q) ? '0 : raddr_inc;
          re_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    full_d = (count_d == DEPTH_V);
    run_d  = (state_d == S_RUN);
    show_d = (state_d == S_RECALL);
    ledr_d = 1'b0;
    ledg_d = 1'b0;
    ledb_d = 1'b0;
    case (state_d)
      S_RUN:    ledg_d = 1'b1;
      S_RECALL: ledb_d = 1'b1;
      default: begin
        ledr_d = !deb_q[2];
        ledb_d = deb_q[2];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= DEB_RST;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      btn_ev_q  <= 1'b0;
      save_ev_q <= 1'b0;
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      clear_q   <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      show_q    <= 1'b0;
      ledr_q    <= 1'b1;
      ledg_q    <= 1'b0;
      ledb_q    <= 1'b0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      btn_ev_q  <= btn_ev_d;
      save_ev_q <= save_ev_d;
      state_q   <= state_d;
      run_q     <= run_d;
      clear_q   <= clear_d;
      we_q      <= we_d;
      re_q      <= re_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      show_q    <= show_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      ledb_q    <= ledb_d;
    end
  end

  assign run           = run_q;
  assign clear         = clear_q;
  assign lap.lap_we    = we_q;
  assign lap.lap_waddr = waddr_q;
  assign lap.lap_re    = re_q;
  assign lap.lap_raddr = raddr_q;
  assign lap.lap_count = count_q;
  assign lap.lap_full  = full_q;
  assign lap.show_lap  = show_q;
  assign ledr          = ledr_q;
  assign ledg          = ledg_q;
  assign ledb          = ledb_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4 and LAP_DEPTH=10.
// A button press becomes an accepted edge 6 clocks after the pin falls:
// 2 synchroniser stages plus 4 stable cycles. Commands appear one clock
// after that edge.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn = 1'b1;
  logic          save = 1'b1;
  logic          outres = 1'b0;
  logic          run, clear, ledr, ledg, ledb;
  logic [1:0]    dbg_state;

  stopwatch_lap_if #(.LAP_AW(AW)) lap_if ();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .LAP_DEPTH(10), .LAP_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .save(save), .outres(outres),
    .run(run), .clear(clear), .lap(lap_if), .ledr(ledr), .ledg(ledg),
    .ledb(ledb), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] we_log[$];
  logic [AW-1:0] re_log[$];
  int          clear_cnt = 0;
  int          wide_pulse = 0;
  logic        prev_we = 1'b0, prev_re = 1'b0, prev_clr = 1'b0;

  // Pulse monitor: records every command pulse and flags any that is wider than one cycle.
  always @(negedge clk) begin
    if (lap_if.lap_we) we_log.push_back(lap_if.lap_waddr);
    if (lap_if.lap_re) re_log.push_back(lap_if.lap_raddr);
    if (clear) clear_cnt++;
    if ((lap_if.lap_we && prev_we) || (lap_if.lap_re && prev_re) || (clear && prev_clr))
      wide_pulse++;
    prev_we  = lap_if.lap_we;
    prev_re  = lap_if.lap_re;
    prev_clr = clear;
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit b, input bit s, input int hold);
    @(negedge clk);
    if (b) btn = 1'b0;
    if (s) save = 1'b0;
    cycles(hold);
    btn  = 1'b1;
    save = 1'b1;
    cycles(14);
  endtask

  // Tests
  task automatic test_reset;
    rst_n = 1'b0;
    cycles(3);
    tests_run++;
    if ({run, clear, lap_if.lap_we, lap_if.lap_re, lap_if.show_lap, lap_if.lap_full} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {run, clear, lap_if.lap_we, lap_if.lap_re, lap_if.show_lap, lap_if.lap_full});
    end
    tests_run++;
    if ({lap_if.lap_waddr, lap_if.lap_raddr, lap_if.lap_count} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h expected 000",
               {lap_if.lap_waddr, lap_if.lap_raddr, lap_if.lap_count});
    end
    tests_run++;
    if ({ledr, ledg, ledb, dbg_state} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_led_state: got %b expected 10000", {ledr, ledg, ledb, dbg_state});
    end
    rst_n = 1'b1;
    cycles(10);
  endtask

  task automatic test_debounce;
    // A 3-cycle glitch is too short to be accepted.
    @(negedge clk);
    btn = 1'b0;
    cycles(3);
    btn = 1'b1;
    cycles(12);
    tests_run++;
    if (run !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL short_press: got run=%b state=%0d expected run=0 state=0", run, dbg_state);
    end
    // A held press: accepted at edge 6, run registered at edge 7.
    @(negedge clk);
    btn = 1'b0;
    cycles(6);
    tests_run++;
    if (run !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_early: got %b expected 0", run);
    end
    cycles(1);
    tests_run++;
    if (run !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_on_time: got %b expected 1", run);
    end
    btn = 1'b1;
    cycles(12);
    tests_run++;
    if ({ledr, ledg, ledb} !== 3'b010 || dbg_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL run_led: got led=%b state=%0d expected led=010 state=1", {ledr, ledg, ledb}, dbg_state);
    end
  endtask

  task automatic test_lap_write;
    we_log.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1, 6);
      exp_q.push_back(AW'(i));
    end
    tests_run++;
    if (we_log.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL lap_we_count: got %0d expected %0d", we_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (we_log[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL lap_waddr[%0d]: got %0d expected %0d", i, we_log[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (lap_if.lap_count !== 4'd3 || run !== 1'b1 || wide_pulse !== 0) begin
      tests_failed++;
      $display("FAIL lap_write_state: got count=%0d run=%b wide=%0d expected 3 1 0",
               lap_if.lap_count, run, wide_pulse);
    end
  endtask

  task automatic test_recall;
    press(1'b1, 1'b0, 6);
    tests_run++;
    if (dbg_state !== 2'd2 || run !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause: got state=%0d run=%b expected 2 0", dbg_state, run);
    end
    outres = 1'b1;
    cycles(12);
    tests_run++;
    if ({ledr, ledg, ledb} !== 3'b001) begin
      tests_failed++;
      $display("FAIL paused_blue: got %b expected 001", {ledr, ledg, ledb});
    end
    re_log.delete();
    exp_q.delete();
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd0);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 6);
    tests_run++;
    if (re_log.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL lap_re_count: got %0d expected %0d", re_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (re_log[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL lap_raddr[%0d]: got %0d expected %0d", i, re_log[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (lap_if.show_lap !== 1'b1 || {ledr, ledg, ledb} !== 3'b001 || dbg_state !== 2'd3) begin
      tests_failed++;
      $display("FAIL recall_state: got show=%b led=%b state=%0d expected 1 001 3",
               lap_if.show_lap, {ledr, ledg, ledb}, dbg_state);
    end
    outres = 1'b0;
    cycles(12);
    tests_run++;
    if (lap_if.show_lap !== 1'b0 || {ledr, ledg, ledb} !== 3'b100 || dbg_state !== 2'd2) begin
      tests_failed++;
      $display("FAIL recall_exit: got show=%b led=%b state=%0d expected 0 100 2",
               lap_if.show_lap, {ledr, ledg, ledb}, dbg_state);
    end
  endtask

  task automatic test_back_to_back;
    int clr0, re0;
    clr0 = clear_cnt;
    re0  = re_log.size();
    press(1'b1, 1'b1, 6);
    tests_run++;
    if (dbg_state !== 2'd1 || run !== 1'b1 || clear_cnt !== clr0 || re_log.size() !== re0 ||
        lap_if.lap_count !== 4'd3) begin
      tests_failed++;
      $display("FAIL simultaneous: got state=%0d run=%b clr=%0d re=%0d count=%0d expected 1 1 %0d %0d 3",
               dbg_state, run, clear_cnt, re_log.size(), lap_if.lap_count, clr0, re0);
    end
  endtask

  task automatic test_lap_full;
    logic [AW-1:0] exp_waddr;
    we_log.delete();
    exp_q.delete();
    for (int i = 3; i < 10; i++) exp_q.push_back(AW'(i));
`ifdef STOPWATCH_LAP_RING_EN
    exp_q.push_back(4'd0);
    exp_waddr = 4'd1;
`else
    exp_waddr = 4'd10;
`endif
    for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 6);
    tests_run++;
    if (we_log.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL full_we_count: got %0d expected %0d", we_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (we_log[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL full_waddr[%0d]: got %0d expected %0d", i, we_log[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (lap_if.lap_count !== 4'd10 || lap_if.lap_full !== 1'b1 || lap_if.lap_waddr !== exp_waddr) begin
      tests_failed++;
      $display("FAIL full_state: got count=%0d full=%b waddr=%0d expected 10 1 %0d",
               lap_if.lap_count, lap_if.lap_full, lap_if.lap_waddr, exp_waddr);
    end
  endtask

  task automatic test_clear;
    int clr0;
    press(1'b1, 1'b0, 6);
    clr0 = clear_cnt;
    press(1'b0, 1'b1, 6);
    tests_run++;
    if (clear_cnt !== clr0 + 1 || wide_pulse !== 0) begin
      tests_failed++;
      $display("FAIL clear_pulse: got %0d wide=%0d expected %0d wide=0", clear_cnt, wide_pulse, clr0 + 1);
    end
    tests_run++;
    if ({lap_if.lap_count, lap_if.lap_waddr, lap_if.lap_raddr} !== 12'h000 || lap_if.lap_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_regs: got %h full=%b expected 000 0",
               {lap_if.lap_count, lap_if.lap_waddr, lap_if.lap_raddr}, lap_if.lap_full);
    end
    tests_run++;
    if (dbg_state !== 2'd0 || {ledr, ledg, ledb} !== 3'b100 || run !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_idle: got state=%0d led=%b run=%b expected 0 100 0", dbg_state, {ledr, ledg, ledb}, run);
    end
  endtask

  task automatic test_reset_mid;
    int we0, re0, clr0;
    press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    tests_run++;
    if (lap_if.lap_count !== 4'd1 || run !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: got count=%0d run=%b expected 1 1", lap_if.lap_count, run);
    end
    we0 = we_log.size(); re0 = re_log.size(); clr0 = clear_cnt;
    @(negedge clk);
    save = 1'b0;
    cycles(4);
    rst_n = 1'b0;
    cycles(3);
    tests_run++;
    if ({run, lap_if.lap_count, lap_if.lap_waddr, ledr, ledg, ledb, dbg_state} !== {1'b0, 8'h00, 3'b100, 2'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %h expected %h",
               {run, lap_if.lap_count, lap_if.lap_waddr, ledr, ledg, ledb, dbg_state}, {1'b0, 8'h00, 3'b100, 2'd0});
    end
    save  = 1'b1;
    rst_n = 1'b1;
    cycles(14);
    tests_run++;
    if (we_log.size() !== we0 || re_log.size() !== re0 || clear_cnt !== clr0 || run !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_abort: got we=%0d re=%0d clr=%0d run=%b state=%0d expected %0d %0d %0d 0 0",
               we_log.size(), re_log.size(), clear_cnt, run, dbg_state, we0, re0, clr0);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_lap_write();
    test_recall();
    test_back_to_back();
    test_lap_full();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
